// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : pio_pkg
//  Purpose  : Shared command codes, FSM encoding and address field offsets for
//             the PIO core, its Wishbone front end and the top wrapper.
//  Revision : 1.0  initial release
// ============================================================================
package pio_pkg;

    localparam logic [3:0] ACT_NONE   = 4'h0;
    localparam logic [3:0] ACT_PUSH   = 4'h1;
    localparam logic [3:0] ACT_PULL   = 4'h2;
    localparam logic [3:0] ACT_STATUS = 4'hF;

    localparam int ADR_BASE_LSB   = 16;
    localparam int ADR_INDEX_LSB  = 8;
    localparam int ADR_MINDEX_LSB = 6;
    localparam int ADR_CODE_LSB   = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;
    localparam logic [2:0] ST_LOCAL = 3'd5;
    localparam logic [2:0] ST_ACK   = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [3:0]  code;
        logic [1:0]  mindex;
        logic [4:0]  index;
    } wb_req_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_wb_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : pio_wb_frontend
//  Purpose  : Wishbone slave decode into one-cycle PIO command pulses with
//             TX/RX flow control, bounded wait and read-data capture.
//  Revision : 1.0  initial release
// ============================================================================
module pio_wb_frontend
    import pio_pkg::*;
#(
    parameter logic [15:0] BASE_HI  = 16'h761c,
    parameter int          READ_LAT = 1,
    parameter int          TIMEOUT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic [1:0]  pio_mindex,
    output logic [4:0]  pio_index,
    output logic [31:0] pio_din,
    output logic [3:0]  pio_action,
    input  logic [31:0] pio_dout,
    input  logic [3:0]  pio_tx_full,
    input  logic [3:0]  pio_rx_empty
);

    localparam logic [7:0] c_timeout  = 8'(TIMEOUT);
    localparam logic [1:0] c_lat_last = 2'(READ_LAT - 1);

    logic [2:0]  r_state;
    wb_req_t     r_req;
    logic [7:0]  r_wait_cnt;
    logic [1:0]  r_lat_cnt;
    logic        r_drop;
    logic [31:0] r_din;
    logic [31:0] r_dat;

    logic        w_hit;
    logic        w_blocked;
    logic [31:0] w_din_next;
    logic        w_unused_adr;

    assign w_hit = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[ADR_BASE_LSB +: 16] == BASE_HI);
    assign w_blocked = ((r_req.code == ACT_PUSH) & pio_tx_full[r_req.mindex]) |
                       ((r_req.code == ACT_PULL) & pio_rx_empty[r_req.mindex]);
    assign w_din_next = r_req.we ? merge_bytes(r_din, r_req.dat, r_req.sel) : r_din;
    assign w_unused_adr = ^{wbs_adr_i[15:13], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_wait_cnt <= 8'd0;
            r_lat_cnt  <= 2'd0;
            r_drop     <= 1'b0;
            r_din      <= 32'd0;
            r_dat      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_hit) begin
                        r_req.we     <= wbs_we_i;
                        r_req.sel    <= wbs_sel_i;
                        r_req.dat    <= wbs_dat_i;
                        r_req.code   <= wbs_adr_i[ADR_CODE_LSB +: 4];
                        r_req.mindex <= wbs_adr_i[ADR_MINDEX_LSB +: 2];
                        r_req.index  <= wbs_adr_i[ADR_INDEX_LSB +: 5];
                        r_state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!wbs_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_req.code == ACT_STATUS) begin
                        r_state <= ST_LOCAL;
                    end else if (w_blocked) begin
                        r_wait_cnt <= 8'd0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_din   <= w_din_next;
                        r_state <= ST_ISSUE;
                    end
                end
                // A release in the same cycle as the timeout reach still issues.
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (!w_blocked) begin
                        r_din   <= w_din_next;
                        r_state <= ST_ISSUE;
                    end else if (r_wait_cnt == c_timeout) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (!wbs_cyc_i) r_drop <= 1'b1;
                    r_lat_cnt <= 2'd0;
                    r_state   <= r_req.we ? ST_ACK : ST_CAPT;
                end
                ST_CAPT: begin
                    if (!wbs_cyc_i) r_drop <= 1'b1;
                    if (r_lat_cnt == c_lat_last) begin
                        r_dat   <= pio_dout;
                        r_state <= ST_ACK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                ST_LOCAL: begin
                    if (!wbs_cyc_i) r_drop <= 1'b1;
                    if (!r_req.we) r_dat <= {24'd0, pio_rx_empty, pio_tx_full};
                    r_state <= ST_ACK;
                end
                ST_ACK:  r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pio_action = (r_state == ST_ISSUE) ? r_req.code : ACT_NONE;
    assign pio_mindex = r_req.mindex;
    assign pio_index  = r_req.index;
    assign pio_din    = r_din;
    assign wbs_dat_o  = r_dat;
    assign wbs_ack_o  = (r_state == ST_ACK) & wbs_cyc_i & ~r_drop;
    assign wbs_err_o  = (r_state == ST_ERR) & wbs_cyc_i;

endmodule
`default_nettype wire

// File: tb/tb_pio_wb_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_wb_frontend
//  Purpose  : Directed vector bench for pio_wb_frontend.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pio_wb_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat, dout;
    logic [3:0]  txf, rxe;

    logic        ack, err, ack_t, err_t;
    logic [31:0] dat_o, din, dat_o_t, din_t;
    logic [1:0]  mindex, mindex_t;
    logic [4:0]  index, index_t;
    logic [3:0]  action, action_t;

    always #5 clk = ~clk;

    pio_wb_frontend dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(dat_o),
        .pio_mindex(mindex), .pio_index(index), .pio_din(din), .pio_action(action),
        .pio_dout(dout), .pio_tx_full(txf), .pio_rx_empty(rxe)
    );

    pio_wb_frontend #(.TIMEOUT(4)) dut_t (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack_t), .wbs_err_o(err_t), .wbs_dat_o(dat_o_t),
        .pio_mindex(mindex_t), .pio_index(index_t), .pio_din(din_t), .pio_action(action_t),
        .pio_dout(dout), .pio_tx_full(txf), .pio_rx_empty(rxe)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  txf;
        logic [3:0]  rxe;
        logic [31:0] dout;
        int          e_nact;
        logic [3:0]  e_act;
        logic [1:0]  e_m;
        logic [4:0]  e_idx;
        int          e_ack;
        logic [31:0] e_din;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[8];
    int   n_vec  = 0;
    int   n_fail = 0;

    int         act_cnt, act_at, ack_cnt, ack_at, err_cnt, err_at;
    int         t_act, t_ack, t_err, t_err_at;
    logic [3:0] act_val;
    logic [1:0] act_m;
    logic [4:0] act_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; dat = 32'd0; dout = 32'd0; txf = 4'h0; rxe = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One WB access; the master drops cyc/stb as soon as the watched DUT completes.
    task automatic run_txn(input logic t_we, input logic [3:0] t_sel,
                           input logic [31:0] t_adr, input logic [31:0] t_dat,
                           input logic [31:0] dout_val, input int release_k,
                           input bit watch_t, input int ncyc);
        act_cnt = 0; act_at = 0; ack_cnt = 0; ack_at = 0; err_cnt = 0; err_at = 0;
        t_act = 0; t_ack = 0; t_err = 0; t_err_at = 0;
        act_val = 4'h0; act_m = 2'd0; act_i = 5'd0;
        dout = 32'hBAD0_BAD0;
        cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; adr = t_adr; dat = t_dat;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            if (action != 4'h0) begin
                act_cnt++; act_at = k; act_val = action; act_m = mindex; act_i = index;
            end
            if (ack) begin ack_cnt++; ack_at = k; end
            if (err) begin err_cnt++; err_at = k; end
            if (action_t != 4'h0) t_act++;
            if (ack_t) t_ack++;
            if (err_t) begin t_err++; t_err_at = k; end
            dout = (act_at != 0 && k == act_at + 1) ? dout_val : 32'hBAD0_BAD0;
            if (k == release_k) begin txf = 4'h0; rxe = 4'h0; end
            if (watch_t ? (ack_t | err_t) : (ack | err)) begin cyc = 1'b0; stb = 1'b0; end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        //                  we    sel    adr            dat            txf    rxe    dout           nact act  m  idx ack din            dat_o
        vecs[0] = '{1'b1, 4'hF, 32'h761C_0044, 32'hDEAD_BEEF, 4'h0, 4'h0, 32'h0,         1, 4'h1, 2'd1, 5'd0,  3, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 4'h2, 32'h761C_0044, 32'h0000_5500, 4'h0, 4'h0, 32'h0,         1, 4'h1, 2'd1, 5'd0,  3, 32'hDEAD_55EF, 32'h0};
        vecs[2] = '{1'b0, 4'hF, 32'h761C_0588, 32'hFFFF_FFFF, 4'h0, 4'h0, 32'h1234_5678, 1, 4'h2, 2'd2, 5'd5,  4, 32'hDEAD_55EF, 32'h1234_5678};
        vecs[3] = '{1'b1, 4'h9, 32'h761C_1FCC, 32'h1122_3344, 4'hF, 4'hF, 32'h0,         1, 4'h3, 2'd3, 5'd31, 3, 32'h11AD_5544, 32'h1234_5678};
        vecs[4] = '{1'b0, 4'hF, 32'h761C_003C, 32'h0,         4'h5, 4'h8, 32'h0,         0, 4'h0, 2'd0, 5'd0,  3, 32'h11AD_5544, 32'h0000_0085};
        vecs[5] = '{1'b1, 4'h4, 32'h761C_0004, 32'h0099_0000, 4'hE, 4'h0, 32'h0,         1, 4'h1, 2'd0, 5'd0,  3, 32'h1199_5544, 32'h0000_0085};
        vecs[6] = '{1'b1, 4'hF, 32'h761D_0044, 32'h5555_5555, 4'h0, 4'h0, 32'h0,         0, 4'h0, 2'd0, 5'd0,  0, 32'h1199_5544, 32'h0000_0085};
        vecs[7] = '{1'b0, 4'hF, 32'h761C_00C8, 32'h0,         4'h0, 4'h7, 32'hA5A5_5A5A, 1, 4'h2, 2'd3, 5'd0,  4, 32'h1199_5544, 32'hA5A5_5A5A};

        do_reset();
        #1;
        chk("rst_ack",    {31'd0, ack},    32'd0);
        chk("rst_err",    {31'd0, err},    32'd0);
        chk("rst_action", {28'd0, action}, 32'd0);
        chk("rst_din",    din,             32'd0);
        chk("rst_dat_o",  dat_o,           32'd0);
        chk("rst_mindex", {30'd0, mindex}, 32'd0);
        chk("rst_index",  {27'd0, index},  32'd0);

        foreach (vecs[i]) begin
            txf = vecs[i].txf; rxe = vecs[i].rxe;
            run_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].dout, 0, 1'b0, 10);
            chk($sformatf("v%0d_nact", i), act_cnt, vecs[i].e_nact);
            if (vecs[i].e_nact != 0) begin
                chk($sformatf("v%0d_action", i), {28'd0, act_val}, {28'd0, vecs[i].e_act});
                chk($sformatf("v%0d_act_at", i), act_at, 2);
                chk($sformatf("v%0d_mindex", i), {30'd0, act_m}, {30'd0, vecs[i].e_m});
                chk($sformatf("v%0d_index", i),  {27'd0, act_i}, {27'd0, vecs[i].e_idx});
            end
            chk($sformatf("v%0d_nack", i), ack_cnt, (vecs[i].e_ack != 0) ? 1 : 0);
            if (vecs[i].e_ack != 0) chk($sformatf("v%0d_ack_at", i), ack_at, vecs[i].e_ack);
            chk($sformatf("v%0d_nerr", i), err_cnt, 0);
            chk($sformatf("v%0d_din", i),   din,   vecs[i].e_din);
            chk($sformatf("v%0d_dat_o", i), dat_o, vecs[i].e_dat);
        end

        // PULL on machine 2 with its RX FIFO empty for ten cycles.
        txf = 4'h0; rxe = 4'h4;
        run_txn(1'b0, 4'hF, 32'h761C_0088, 32'h0, 32'h1234_5678, 10, 1'b0, 20);
        chk("wait_nact",   act_cnt, 1);
        chk("wait_act_at", act_at, 11);
        chk("wait_action", {28'd0, act_val}, 32'd2);
        chk("wait_nack",   ack_cnt, 1);
        chk("wait_ack_at", ack_at, 13);
        chk("wait_nerr",   err_cnt, 0);
        chk("wait_dat_o",  dat_o, 32'h1234_5678);

        // TX full held: TIMEOUT=4 instance errors, default instance is aborted by cyc drop.
        do_reset();
        txf = 4'h2; rxe = 4'h0;
        run_txn(1'b1, 4'hF, 32'h761C_0044, 32'h0BAD_F00D, 32'h0, 0, 1'b1, 16);
        chk("to_nerr",    t_err, 1);
        chk("to_err_at",  t_err_at, 7);
        chk("to_nack",    t_ack, 0);
        chk("to_nact",    t_act, 0);
        chk("to_din",     din_t, 32'd0);
        chk("abort_nack", ack_cnt, 0);
        chk("abort_nerr", err_cnt, 0);
        chk("abort_nact", act_cnt, 0);
        chk("abort_din",  din, 32'd0);

        // Reset asserted while the action pulse is on the bus.
        txf = 4'h0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h761C_0044; dat = 32'h0BAD_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ri_action_pre", {28'd0, action}, 32'd1);
        chk("ri_din_pre",    din, 32'h0BAD_F00D);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("ri_action", {28'd0, action}, 32'd0);
        chk("ri_ack",    {31'd0, ack},    32'd0);
        chk("ri_err",    {31'd0, err},    32'd0);
        chk("ri_din",    din,             32'd0);
        chk("ri_mindex", {30'd0, mindex}, 32'd0);
        @(posedge clk); #1;
        chk("ri_ack2",   {31'd0, ack},    32'd0);
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
